spm_seq: RTL and testbench

Sequencer for the serial-parallel multiplier (`spm`) array of carry-save cells. It accepts one signed operand pair over a valid/ready handshake and holds `x` as the parallel operand. It flushes the CSA state, streams `y` LSB-first (sign-extended) into the array, and deserialises the serial product into a 2·SIZE-bit result returned over a second valid/ready handshake. One multiplication is in flight at a time.

---
 rtl/spm_seq.sv | 128 ++++++++++++
 tb/tb_spm_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_seq.sv
// spm_seq: control and data sequencer for a serial-parallel carry-save multiplier array.
// It accepts one signed operand pair, holds x on the array's parallel input and flushes
// the array. It then streams sign-extended y LSB-first and collects the serial product
// into a 2*SIZE-bit result.
module spm_seq #(
    parameter int SIZE = 32,
    parameter int LAT  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [SIZE-1:0]   in_x,
    input  logic signed [SIZE-1:0]   in_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [2*SIZE-1:0] out_p,
    output logic                     busy,
    output logic signed [SIZE-1:0]   spm_x,
    output logic                     spm_y,
    output logic                     spm_clr,
    input  logic                     spm_p
);
    localparam int PW    = 2 * SIZE;
    localparam int TOTAL = PW + LAT;
    localparam int CNT_W = $clog2(TOTAL + 1);

    // Last SHIFT count value and first count at which spm_p carries a product bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic signed [SIZE-1:0] y_sr;
    logic signed [PW-1:0]   prod;
    logic [CNT_W-1:0]       cnt;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/array strobes, decoded from state and registers only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        spm_clr   = 1'b0;
        spm_y     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                spm_clr   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                spm_y = y_sr[0];
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, y serialisation, SHIFT counter and product deserialisation.
    // The arithmetic shift of y replicates its sign bit, so the upper SIZE bits sent
    // are sign extension. The first LAT samples of spm_p precede any product bit and
    // are skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spm_x <= '0;
            y_sr  <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        spm_x <= in_x;
                        y_sr  <= in_y;
                    end
                end
                CLEAR: begin
                    cnt <= '0;
                end
                SHIFT: begin
                    y_sr <= y_sr >>> 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt >= CNT_LAT) begin
                        prod <= {spm_p, prod[PW-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_p = prod;

endmodule

// File: tb/tb_spm_seq.sv
// Testbench for spm_seq with a behavioural serial-parallel multiplier array (SIZE=4, LAT=1).
module tb_spm_seq;
    localparam int SIZE = 4;
    localparam int LAT  = 1;
    localparam int PW   = 2 * SIZE;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_x;
    logic [SIZE-1:0] in_y;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   out_p;
    logic            busy;
    logic [SIZE-1:0] spm_x;
    logic            spm_y;
    logic            spm_clr;
    logic            spm_p;

    int n_checks = 0;
    int n_pass   = 0;

    spm_seq #(.SIZE(SIZE), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_clr   (spm_clr),
        .spm_p     (spm_p)
    );

    always #5 clk = ~clk;

    // Behavioural array: it accumulates the y bits received since the last flush.
    // One cycle after y bit n arrives, it presents bit n of x*y_received.
    int unsigned mdl_n    = 0;
    longint      mdl_yacc = 0;
    logic        mdl_p    = 1'b0;

    always @(posedge clk) begin
        longint xs;
        longint pr;
        if (spm_clr) begin
            mdl_n    = 0;
            mdl_yacc = 0;
            mdl_p   <= 1'b0;
        end else if (mdl_n < PW) begin
            mdl_yacc = mdl_yacc + (longint'(spm_y) << mdl_n);
            xs       = longint'($signed(spm_x));
            pr       = xs * mdl_yacc;
            mdl_p   <= pr[mdl_n[5:0]];
            mdl_n    = mdl_n + 1;
        end
    end

    assign spm_p = mdl_p;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
        longint xs;
        longint ys;
        xs = longint'($signed(x));
        ys = longint'($signed(y));
        return PW'(xs * ys);
    endfunction

    function automatic logic [PW-1:0] sext_y(input logic [SIZE-1:0] y);
        return PW'(longint'($signed(y)));
    endfunction

    // One full operation from IDLE, with bp cycles of output backpressure in DONE.
    task automatic do_op(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y, input int bp);
        logic [PW-1:0] exp_p;
        logic [PW-1:0] ybits;
        logic [PW-1:0] p_hold;
        int            cyc;
        int            clr_cnt;
        bit            got;
        exp_p = ref_mul(x, y);
        ybits = '0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        @(negedge clk);
        in_valid = 1'b0;
        check("clear_spm_clr", 64'(spm_clr), 64'(1));
        check("clear_busy", 64'(busy), 64'(1));
        check("clear_in_ready", 64'(in_ready), 64'(0));
        clr_cnt = 1;
        cyc     = 0;
        got     = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (spm_clr) clr_cnt++;
            if (cyc >= 1 && cyc <= PW) ybits[cyc-1] = spm_y;
            if (out_valid) got = 1'b1;
        end
        check("out_valid_cycle", 64'(cyc), 64'(PW + LAT + 1));
        check("spm_y_stream", 64'(ybits), 64'(sext_y(y)));
        check("clr_pulses", 64'(clr_cnt), 64'(1));
        check("spm_x_done", 64'(spm_x), 64'(x));
        p_hold = out_p;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            in_x     = ~x;
            in_y     = ~y;
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_out_p", 64'(out_p), 64'(p_hold));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        check("out_p", 64'(out_p), 64'(exp_p));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_valid", 64'(out_valid), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_spm_x", 64'(spm_x), 64'(x));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            c1;
        int            c2;
        int            cclr2;
        int            clr_cnt;
        logic [PW-1:0] p1;
        logic [PW-1:0] p2;
        bit            stale;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_spm_clr", 64'(spm_clr), 64'(0));
        check("rst_spm_y", 64'(spm_y), 64'(0));
        check("rst_spm_x", 64'(spm_x), 64'(0));
        check("rst_out_p", 64'(out_p), 64'(0));
        rst = 1'b0;

        do_op(4'd3, 4'd5, 0);
        do_op(4'hE, 4'd3, 0);
        do_op(4'd7, 4'hF, 0);
        do_op(4'd0, 4'h9, 0);
        do_op(4'h8, 4'h8, 0);
        do_op(4'd6, 4'hB, 5);

        // Back-to-back: in_valid stays high across two operations, consumer always ready.
        @(negedge clk);
        in_valid  = 1'b1;
        in_x      = 4'd3;
        in_y      = 4'd5;
        out_ready = 1'b1;
        @(negedge clk);
        in_x    = 4'hE;
        in_y    = 4'd3;
        clr_cnt = spm_clr ? 1 : 0;
        c1 = -1; c2 = -1; cclr2 = -1;
        p1 = '0; p2 = '0;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            if (spm_clr) begin
                clr_cnt++;
                if (cclr2 < 0) cclr2 = cyc;
                check("b2b_spm_x", 64'(spm_x), 64'(4'hE));
                in_valid = 1'b0;
            end
            if (cyc == PW + LAT + 2) check("b2b_idle_ready", 64'(in_ready), 64'(1));
            if (out_valid) begin
                if (c1 < 0) begin
                    c1 = cyc; p1 = out_p;
                end else if (c2 < 0) begin
                    c2 = cyc; p2 = out_p;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_c1", 64'(c1), 64'(PW + LAT + 1));
        check("b2b_clr2_cycle", 64'(cclr2), 64'(PW + LAT + 3));
        check("b2b_c2", 64'(c2), 64'(2 * (PW + LAT + 1) + 2));
        check("b2b_clr_pulses", 64'(clr_cnt), 64'(2));
        check("b2b_p1", 64'(p1), 64'(8'h0F));
        check("b2b_p2", 64'(p2), 64'(8'hFA));

        // Reset in the middle of SHIFT (counter = 3).
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 4'd6;
        in_y     = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_spm_y", 64'(spm_y), 64'(0));
        check("mid_rst_spm_x", 64'(spm_x), 64'(0));
        @(negedge clk);
        rst   = 1'b0;
        stale = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("no_stale_result", 64'(stale), 64'(0));
        do_op(4'd5, 4'd5, 0);

        // Randomised operands and backpressure.
        for (int k = 0; k < 12; k++) begin
            do_op(SIZE'($urandom), SIZE'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
